// File: rtl/slot_alloc_arbiter_pkg.sv
// Shared utilities for the slot allocator: default parameter values and
// width-derivation helpers.
package slot_alloc_arbiter_pkg;

  localparam int unsigned DefaultNumReq  = 4;
  localparam int unsigned DefaultNumSlot = 8;

  // Width of an index into n items.
  function automatic int unsigned idx_width(int unsigned n);
    return $clog2(n);
  endfunction

  // Width of a count ranging over 0..n inclusive.
  function automatic int unsigned cnt_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/count_one.sv
// Population count of an InputWidth-bit vector.
//   in_i  : vector to count
//   cnt_o : number of set bits in in_i
module count_one #(
  parameter int unsigned InputWidth = 8,
  localparam int unsigned OutW      = $clog2(InputWidth + 1)
) (
  input  logic [InputWidth-1:0] in_i,
  output logic [OutW-1:0]       cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < InputWidth; i++) begin
      cnt_o = cnt_o + OutW'(in_i[i]);
    end
  end

endmodule

// File: rtl/slot_alloc_arbiter.sv
// Round-robin arbiter that hands out slots from a shared pool of NumSlot.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   req_i            : per-requester level requests
//   gnt_o            : one-hot grant, same cycle as the request
//   gnt_slot_o       : slot index carried by the current grant
//   free_i/free_slot_i : release one allocated slot
//   flush_i          : release every slot
//   used_cnt_o, full_o, empty_o : occupancy from the registered bitmap
//   err_o            : sticky flag for a release of an unallocated slot
module slot_alloc_arbiter
  import slot_alloc_arbiter_pkg::*;
#(
  parameter int unsigned NumReq  = DefaultNumReq,
  parameter int unsigned NumSlot = DefaultNumSlot,
  localparam int unsigned IdxW   = idx_width(NumSlot),
  localparam int unsigned CntW   = cnt_width(NumSlot)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_slot_o,
  input  logic              free_i,
  input  logic [IdxW-1:0]   free_slot_i,
  input  logic              flush_i,
  output logic [CntW-1:0]   used_cnt_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              err_o
);

  localparam int unsigned RrW = idx_width(NumReq);

  logic [NumSlot-1:0] bitmap_q, bitmap_d;
  logic [RrW-1:0]     rr_q, rr_d;
  logic               err_q, err_d;

  logic               req_found;
  logic [RrW-1:0]     req_idx;
  logic               any_free;
  logic [IdxW-1:0]    free_idx;
  logic               gnt_valid;
  logic               free_hit;

  // Requester search: first pass covers rr_q..NumReq-1, second pass the wrap.
  always_comb begin
    req_found = 1'b0;
    req_idx   = '0;
    for (int unsigned j = 0; j < NumReq; j++) begin
      if (!req_found && req_i[j] && (RrW'(j) >= rr_q)) begin
        req_found = 1'b1;
        req_idx   = RrW'(j);
      end
    end
    for (int unsigned j = 0; j < NumReq; j++) begin
      if (!req_found && req_i[j]) begin
        req_found = 1'b1;
        req_idx   = RrW'(j);
      end
    end
  end

  // Lowest clear bit of the registered bitmap.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int unsigned i = 0; i < NumSlot; i++) begin
      if (!any_free && !bitmap_q[i]) begin
        any_free = 1'b1;
        free_idx = IdxW'(i);
      end
    end
  end

  // Out-of-range free_slot_i matches no bit and therefore reads as clear.
  always_comb begin
    free_hit = 1'b0;
    for (int unsigned i = 0; i < NumSlot; i++) begin
      if (IdxW'(i) == free_slot_i) begin
        free_hit = bitmap_q[i];
      end
    end
  end

  assign gnt_valid  = req_found && any_free && !flush_i && !rst_i;
  assign gnt_slot_o = free_idx;

  always_comb begin
    gnt_o = '0;
    if (gnt_valid) begin
      gnt_o[req_idx] = 1'b1;
    end
  end

  always_comb begin
    bitmap_d = bitmap_q;
    rr_d     = rr_q;
    err_d    = err_q;
    if (free_i && !free_hit) begin
      err_d = 1'b1;
    end
    if (flush_i) begin
      bitmap_d = '0;
    end else begin
      if (free_i && free_hit) begin
        bitmap_d[free_slot_i] = 1'b0;
      end
      // Granted slot is clear, so it never collides with a legal free.
      if (gnt_valid) begin
        bitmap_d[free_idx] = 1'b1;
        rr_d = (req_idx == RrW'(NumReq - 1)) ? '0 : req_idx + RrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bitmap_q <= '0;
      rr_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      bitmap_q <= bitmap_d;
      rr_q     <= rr_d;
      err_q    <= err_d;
    end
  end

  count_one #(
    .InputWidth(NumSlot)
  ) u_count_one (
    .in_i (bitmap_q),
    .cnt_o(used_cnt_o)
  );

  assign full_o  = (used_cnt_o == CntW'(NumSlot));
  assign empty_o = (used_cnt_o == '0);
  assign err_o   = err_q;

endmodule

// File: tb/tb_slot_alloc_arbiter.sv
module tb_slot_alloc_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0 drives the 8-slot instance, index 1 the 6-slot instance.
  logic [3:0] req   [2];
  logic       free  [2];
  logic [2:0] fslot [2];
  logic       flush [2];

  logic [3:0] gnt8, gnt6;
  logic [2:0] gs8, gs6;
  logic [3:0] cnt8;
  logic [2:0] cnt6;
  logic       full8, full6, empty8, empty6, err8, err6;

  slot_alloc_arbiter #(.NumReq(4), .NumSlot(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .gnt_o(gnt8), .gnt_slot_o(gs8),
    .free_i(free[0]), .free_slot_i(fslot[0]), .flush_i(flush[0]),
    .used_cnt_o(cnt8), .full_o(full8), .empty_o(empty8), .err_o(err8)
  );

  slot_alloc_arbiter #(.NumReq(4), .NumSlot(6)) u_dut6 (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .gnt_o(gnt6), .gnt_slot_o(gs6),
    .free_i(free[1]), .free_slot_i(fslot[1]), .flush_i(flush[1]),
    .used_cnt_o(cnt6), .full_o(full6), .empty_o(empty6), .err_o(err6)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit started = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of occupied slots, a rotating start pointer and
  // a sticky error bit per instance.
  bit occ [2][64];
  int rr  [2];
  bit err [2];
  int ns  [2] = '{8, 6};

  function automatic int m_used(int k);
    int c = 0;
    for (int s = 0; s < ns[k]; s++) if (occ[k][s]) c++;
    return c;
  endfunction

  function automatic int m_slot(int k);
    for (int s = 0; s < ns[k]; s++) if (!occ[k][s]) return s;
    return -1;
  endfunction

  function automatic int m_gnt(int k);
    if (rst || flush[k] || m_slot(k) < 0) return -1;
    for (int i = 0; i < 4; i++) if (req[k][(rr[k] + i) % 4]) return (rr[k] + i) % 4;
    return -1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int s = 0; s < 64; s++) occ[k][s] = 0;
        rr[k]  = 0;
        err[k] = 0;
      end else begin
        int g, s, f;
        bit legal;
        g = m_gnt(k);
        s = m_slot(k);
        f = int'(fslot[k]);
        legal = (f < ns[k]) && occ[k][f];
        if (free[k] && !legal) err[k] = 1;
        if (flush[k]) begin
          for (int t = 0; t < 64; t++) occ[k][t] = 0;
        end else begin
          if (free[k] && legal) occ[k][f] = 0;
          if (g >= 0) begin
            occ[k][s] = 1;
            rr[k] = (g + 1) % 4;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        int g, u;
        logic [3:0] a_gnt;
        logic [2:0] a_gs;
        logic [3:0] a_cnt;
        logic a_full, a_empty, a_err;
        g = m_gnt(k);
        u = m_used(k);
        a_gnt   = (k == 0) ? gnt8 : gnt6;
        a_gs    = (k == 0) ? gs8 : gs6;
        a_cnt   = (k == 0) ? cnt8 : {1'b0, cnt6};
        a_full  = (k == 0) ? full8 : full6;
        a_empty = (k == 0) ? empty8 : empty6;
        a_err   = (k == 0) ? err8 : err6;
        check("model_gnt", a_gnt, (g < 0) ? 0 : (1 << g));
        if (g >= 0) check("model_slot", a_gs, m_slot(k));
        check("model_used", a_cnt, u);
        check("model_full", a_full, u == ns[k]);
        check("model_empty", a_empty, u == 0);
        check("model_err", a_err, err[k]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      req[k] = '0; free[k] = 0; fslot[k] = '0; flush[k] = 0;
    end
    rst = 1;
    cyc(); cyc();
    rst = 0;
    started = 1;
    #3;
    check("reset_used", cnt8, 0);
    check("reset_empty", empty8, 1);
    check("reset_full", full8, 0);
    check("reset_err", err8, 0);

    // Fill all eight slots round-robin.
    cyc();
    req[0] = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #3;
      check("fill_gnt", gnt8, 4'b0001 << (i % 4));
      check("fill_slot", gs8, i);
      cyc();
    end
    #3;
    check("full_flag", full8, 1);
    check("full_used", cnt8, 8);
    check("full_nogrant", gnt8, 0);

    // Free while full: no bypass.
    cyc();
    req[0] = 4'b0100; free[0] = 1; fslot[0] = 3'd3;
    #3;
    check("nobypass_gnt", gnt8, 0);
    cyc();
    free[0] = 0;
    #3;
    check("afterfree_gnt", gnt8, 4'b0100);
    check("afterfree_slot", gs8, 3);

    // Flush, then use slots 0..2 (rr now 3, so requester 0 wins by wrap).
    cyc();
    req[0] = 4'b0000; flush[0] = 1;
    cyc();
    flush[0] = 0; req[0] = 4'b0001;
    cyc(); cyc(); cyc();
    free[0] = 1; fslot[0] = 3'd1;
    #3;
    check("simul_slot", gs8, 3);
    check("simul_used_before", cnt8, 3);
    cyc();
    free[0] = 0;
    #3;
    check("simul_used_after", cnt8, 3);
    check("hole_slot", gs8, 1);
    cyc();  // slot 1 granted: slots 0..3 used

    // Illegal free of slot 5.
    req[0] = 4'b0000; free[0] = 1; fslot[0] = 3'd5;
    #3;
    check("illegal_err_before", err8, 0);
    cyc();
    free[0] = 0;
    #3;
    check("illegal_err_after", err8, 1);
    check("illegal_used", cnt8, 4);
    req[0] = 4'b0001;
    cyc();  // slot 4 granted, 5 used, rr = 1

    // Flush with requests active.
    req[0] = 4'b1111; flush[0] = 1;
    #3;
    check("flush_used_before", cnt8, 5);
    check("flush_gnt", gnt8, 0);
    cyc();
    flush[0] = 0;
    #3;
    check("flush_used_after", cnt8, 0);
    check("flush_empty", empty8, 1);
    check("flush_err_sticky", err8, 1);
    check("flush_rr_hold", gnt8, 4'b0010);
    cyc();

    // Reset mid-operation suppresses grants and clears err.
    rst = 1;
    #3;
    check("rst_gnt", gnt8, 0);
    cyc();
    rst = 0; req[0] = 4'b0000;
    #3;
    check("rst_err", err8, 0);
    check("rst_used", cnt8, 0);

    // Six-slot instance.
    cyc();
    req[1] = 4'b1111;
    for (int i = 0; i < 6; i++) cyc();
    #3;
    check("six_used", cnt6, 6);
    check("six_full", full6, 1);
    check("six_nogrant", gnt6, 0);
    cyc();
    req[1] = 4'b0000; free[1] = 1; fslot[1] = 3'd7;
    cyc();
    free[1] = 0;
    #3;
    check("six_err", err6, 1);
    check("six_used_kept", cnt6, 6);
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
